sal_bank_req_router: RTL and testbench

SAL_BANK_REQ_ROUTER -- requirements
Module: sal_bank_req_router

---
 rtl/sal_bank_req_router.sv | 128 ++++++++++++
 tb/tb_sal_bank_req_router.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_bank_req_router.sv
// sal_bank_req_router: decodes each incoming request address into
// bank/row/column fields and queues it in the FIFO of its target bank.
// Each bank drains independently through its own valid/ready handshake.
module sal_bank_req_router #(
   parameter int unsigned BK_CNT   = 4,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned ID_W     = 4,
   parameter int unsigned LEN_W    = 4,
   parameter int unsigned OFS_W    = 3,
   parameter int unsigned CA_W     = 10,
   parameter int unsigned RA_W     = 14,
   parameter int unsigned MAP_MODE = 0
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   a_valid,
   output logic                                   a_ready,
   input  logic [ID_W-1:0]                        a_id,
   input  logic [ADDR_W-1:0]                      a_addr,
   input  logic [LEN_W-1:0]                       a_len,
   input  logic                                   a_wr,
   output logic [BK_CNT-1:0]                      bk_valid,
   input  logic [BK_CNT-1:0]                      bk_ready,
   output logic [BK_CNT*ID_W-1:0]                 bk_id,
   output logic [BK_CNT*RA_W-1:0]                 bk_ra,
   output logic [BK_CNT*CA_W-1:0]                 bk_ca,
   output logic [BK_CNT*LEN_W-1:0]                bk_len,
   output logic [BK_CNT-1:0]                      bk_wr,
   output logic [BK_CNT*$clog2(DEPTH+1)-1:0]      bk_level
);

   localparam int unsigned BA_W  = $clog2(BK_CNT);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH+1);
   localparam int unsigned ENT_W = ID_W + RA_W + CA_W + LEN_W + 1;
   localparam int unsigned TOP   = OFS_W + CA_W + BA_W + RA_W;

   logic [ENT_W-1:0] mem_q [BK_CNT][DEPTH];
   logic [ENT_W-1:0] mem_d [BK_CNT][DEPTH];
   logic [PTR_W-1:0] wp_q  [BK_CNT];
   logic [PTR_W-1:0] wp_d  [BK_CNT];
   logic [PTR_W-1:0] rp_q  [BK_CNT];
   logic [PTR_W-1:0] rp_d  [BK_CNT];
   logic [LVL_W-1:0] lvl_q [BK_CNT];
   logic [LVL_W-1:0] lvl_d [BK_CNT];

   logic [CA_W-1:0]  ca;
   logic [BA_W-1:0]  raw_ba;
   logic [RA_W-1:0]  ra;
   logic [BA_W-1:0]  ba;
   logic             push_en;
   logic [BK_CNT-1:0] push;
   logic [BK_CNT-1:0] pop;

   // address bits outside the mapped fields carry no meaning here
   logic unused_addr;
   assign unused_addr = ^{a_addr[ADDR_W-1:TOP], a_addr[OFS_W-1:0]};

   // address decode, bank selection and admission (full is judged on the
   // pre-edge level so a pop never frees space for a same-cycle push)
   always_comb begin
      ca     = a_addr[OFS_W +: CA_W];
      raw_ba = a_addr[OFS_W+CA_W +: BA_W];
      ra     = a_addr[OFS_W+CA_W+BA_W +: RA_W];
      if (MAP_MODE == 1) ba = raw_ba ^ ra[BA_W-1:0];
      else               ba = raw_ba;
      a_ready = (lvl_q[ba] != LVL_W'(DEPTH));
      push_en = a_valid && a_ready;
   end

   // per-bank FIFO next state: push into the decoded bank, pop on handshake
   always_comb begin
      mem_d = mem_q;
      wp_d  = wp_q;
      rp_d  = rp_q;
      lvl_d = lvl_q;
      push  = '0;
      pop   = '0;
      for (int unsigned i = 0; i < BK_CNT; i++) begin
         push[i] = push_en && (ba == BA_W'(i));
         pop[i]  = (lvl_q[i] != '0) && bk_ready[i];
         if (push[i]) begin
            mem_d[i][wp_q[i]] = {a_id, ra, ca, a_len, a_wr};
            wp_d[i] = wp_q[i] + 1'b1;
         end
         if (pop[i]) rp_d[i] = rp_q[i] + 1'b1;
         case ({push[i], pop[i]})
            2'b10:   lvl_d[i] = lvl_q[i] + 1'b1;
            2'b01:   lvl_d[i] = lvl_q[i] - 1'b1;
            default: lvl_d[i] = lvl_q[i];
         endcase
      end
   end

   // state registers; reset wipes storage so outputs read as zero
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
         wp_q  <= '{default: '0};
         rp_q  <= '{default: '0};
         lvl_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         lvl_q <= lvl_d;
      end
   end

   // present each bank's head entry and occupancy
   always_comb begin
      bk_valid = '0;
      bk_id    = '0;
      bk_ra    = '0;
      bk_ca    = '0;
      bk_len   = '0;
      bk_wr    = '0;
      bk_level = '0;
      for (int unsigned i = 0; i < BK_CNT; i++) begin
         bk_valid[i] = (lvl_q[i] != '0);
         {bk_id[i*ID_W +: ID_W], bk_ra[i*RA_W +: RA_W], bk_ca[i*CA_W +: CA_W],
          bk_len[i*LEN_W +: LEN_W], bk_wr[i]} = mem_q[i][rp_q[i]];
         bk_level[i*LVL_W +: LVL_W] = lvl_q[i];
      end
   end

endmodule

// File: tb/tb_sal_bank_req_router.sv
// Bench for sal_bank_req_router: one plain-mapped and one XOR-mapped
// instance share stimulus; a queue-per-bank model predicts every output.
module tb_sal_bank_req_router;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0;
   logic [3:0]  a_id = '0;
   logic [31:0] a_addr = '0;
   logic [3:0]  a_len = '0;
   logic        a_wr = 1'b0;
   logic [3:0]  bk_ready = '0;

   logic        ar0, ar1;
   logic [3:0]  v0, v1, wr0, wr1;
   logic [15:0] id0, id1, len0, len1;
   logic [55:0] ra0, ra1;
   logic [39:0] ca0, ca1;
   logic [7:0]  lvl0, lvl1;

   int checks = 0;
   int errors = 0;
   bit started = 0;

   always #5 clk = ~clk;

   sal_bank_req_router #(.MAP_MODE(0)) u0 (
      .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(ar0), .a_id(a_id),
      .a_addr(a_addr), .a_len(a_len), .a_wr(a_wr), .bk_valid(v0),
      .bk_ready(bk_ready), .bk_id(id0), .bk_ra(ra0), .bk_ca(ca0),
      .bk_len(len0), .bk_wr(wr0), .bk_level(lvl0));

   sal_bank_req_router #(.MAP_MODE(1)) u1 (
      .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(ar1), .a_id(a_id),
      .a_addr(a_addr), .a_len(a_len), .a_wr(a_wr), .bk_valid(v1),
      .bk_ready(bk_ready), .bk_id(id1), .bk_ra(ra1), .bk_ca(ca1),
      .bk_len(len1), .bk_wr(wr1), .bk_level(lvl1));

   typedef struct {
      logic [3:0]  id;
      logic [13:0] ra;
      logic [9:0]  ca;
      logic [3:0]  len;
      logic        wr;
   } ent_t;

   // queue index = mode*4 + bank
   ent_t mq[8][$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic void decode(input logic [31:0] addr, input int m,
                                  output int b, output ent_t e);
      int unsigned s;
      int unsigned raw;
      s    = addr >> 3;
      e.ca = 10'(s % 1024);
      raw  = (s / 1024) % 4;
      e.ra = 14'((s / 4096) % 16384);
      b    = (m == 1) ? int'(raw ^ (e.ra % 4)) : int'(raw);
      e.id = a_id;
      e.len = a_len;
      e.wr = a_wr;
   endfunction

   // reference model advances on each edge from the inputs it saw
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 8; k++) mq[k].delete();
      end else begin
         for (int m = 0; m < 2; m++) begin
            int b;
            ent_t e;
            bit take;
            decode(a_addr, m, b, e);
            take = a_valid && (mq[m*4+b].size() < 2);
            for (int i = 0; i < 4; i++)
               if (mq[m*4+i].size() > 0 && bk_ready[i]) void'(mq[m*4+i].pop_front());
            if (take) mq[m*4+b].push_back(e);
         end
      end
   end

   task automatic cmp(input int m, input logic [3:0] v, input logic [15:0] id,
                      input logic [55:0] ra, input logic [39:0] ca, input logic [15:0] len,
                      input logic [3:0] wr, input logic [7:0] lvl, input logic ar);
      for (int b = 0; b < 4; b++) begin
         int n;
         ent_t h;
         n = mq[m*4+b].size();
         chk($sformatf("i%0d_b%0d_valid", m, b), 64'(v[b]), 64'(n != 0));
         chk($sformatf("i%0d_b%0d_level", m, b), 64'(lvl[b*2 +: 2]), 64'(n));
         if (n > 0) begin
            h = mq[m*4+b][0];
            chk($sformatf("i%0d_b%0d_head", m, b),
                64'({id[b*4 +: 4], ra[b*14 +: 14], ca[b*10 +: 10], len[b*4 +: 4], wr[b]}),
                64'({h.id, h.ra, h.ca, h.len, h.wr}));
         end
      end
      if (a_valid) begin
         int b;
         ent_t e;
         decode(a_addr, m, b, e);
         chk($sformatf("i%0d_a_ready", m), 64'(ar), 64'(mq[m*4+b].size() < 2));
      end
   endtask

   // single compare process against the model, away from the active edge
   always @(negedge clk) begin
      if (started) begin
         cmp(0, v0, id0, ra0, ca0, len0, wr0, lvl0, ar0);
         cmp(1, v1, id1, ra1, ca1, len1, wr1, lvl1, ar1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_valid = 1'b0;
      bk_ready = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic req(input logic [31:0] addr, input logic [3:0] id);
      a_valid = 1'b1;
      a_addr = addr;
      a_id = id;
      a_len = 4'd3;
      a_wr = 1'b1;
   endtask

   initial begin
      #1;
      do_reset();
      started = 1;

      // reset state
      @(negedge clk);
      chk("rst_valid", 64'({v0, v1}), 64'h0);
      chk("rst_level", 64'({lvl0, lvl1}), 64'h0);
      chk("rst_fields", 64'(|{id0, ra0, ca0, len0, wr0}), 64'h0);
      chk("rst_a_ready", 64'({ar0, ar1}), 64'h3);

      // plain mapping example
      do_reset();
      req(32'h0000_6008, 4'd5);
      @(negedge clk);
      chk("d19_a_ready", 64'(ar0), 64'h1);
      tick();
      a_valid = 1'b0;
      @(negedge clk);
      chk("d19_valid", 64'(v0), 64'h8);
      chk("d19_id", 64'(id0[15:12]), 64'h5);
      chk("d19_ra", 64'(ra0[55:42]), 64'h0);
      chk("d19_ca", 64'(ca0[39:30]), 64'h1);
      chk("d19_len", 64'(len0[15:12]), 64'h3);
      chk("d19_wr", 64'(wr0[3]), 64'h1);

      // hashed mapping example
      do_reset();
      req(32'h0000_E008, 4'd9);
      tick();
      a_valid = 1'b0;
      @(negedge clk);
      chk("d20_valid", 64'(v1), 64'h4);
      chk("d20_ra", 64'(ra1[28 +: 14]), 64'h1);
      chk("d20_ca", 64'(ca1[20 +: 10]), 64'h1);

      // fill bank 0, third request must wait
      do_reset();
      req(32'h0, 4'd0); tick();
      req(32'h0, 4'd1); tick();
      req(32'h0, 4'd2);
      @(negedge clk);
      chk("d21_full_ready", 64'(ar0), 64'h0);
      chk("d21_full_level", 64'(lvl0[1:0]), 64'h2);
      chk("d21_head0", 64'(id0[3:0]), 64'h0);
      tick();
      bk_ready = 4'b0001;
      tick();
      bk_ready = '0;
      @(negedge clk);
      chk("d21_head1", 64'(id0[3:0]), 64'h1);
      chk("d21_level1", 64'(lvl0[1:0]), 64'h1);
      chk("d21_ready_again", 64'(ar0), 64'h1);
      tick();
      a_valid = 1'b0;
      @(negedge clk);
      chk("d21_level2", 64'(lvl0[1:0]), 64'h2);
      bk_ready = 4'b0001;
      tick();
      bk_ready = '0;
      @(negedge clk);
      chk("d21_head2", 64'(id0[3:0]), 64'h2);

      // full bank 1 must not block bank 2
      do_reset();
      req(32'h2000, 4'd1); tick();
      req(32'h2000, 4'd2); tick();
      req(32'h4000, 4'd3);
      @(negedge clk);
      chk("d22_b1_level", 64'(lvl0[3:2]), 64'h2);
      chk("d22_b2_ready", 64'(ar0), 64'h1);
      tick();
      a_valid = 1'b0;
      @(negedge clk);
      chk("d22_b2_valid", 64'(v0[2]), 64'h1);
      chk("d22_b2_id", 64'(id0[11:8]), 64'h3);

      // simultaneous push and pop at level 1
      do_reset();
      req(32'h0, 4'd7); tick();
      req(32'h0, 4'd8);
      bk_ready = 4'b0001;
      tick();
      a_valid = 1'b0;
      bk_ready = '0;
      @(negedge clk);
      chk("d23_level", 64'(lvl0[1:0]), 64'h1);
      chk("d23_head", 64'(id0[3:0]), 64'h8);

      // reset with bank 3 full and a request in flight
      do_reset();
      req(32'h6000, 4'd1); tick();
      req(32'h6000, 4'd2); tick();
      a_valid = 1'b0;
      @(negedge clk);
      chk("d24_pre_level", 64'(lvl0[7:6]), 64'h2);
      rst = 1'b1;
      req(32'h6000, 4'd4);
      tick();
      rst = 1'b0;
      a_valid = 1'b0;
      @(negedge clk);
      chk("d24_valid", 64'({v0, v1}), 64'h0);
      chk("d24_level", 64'({lvl0, lvl1}), 64'h0);
      chk("d24_a_ready", 64'({ar0, ar1}), 64'h3);
      chk("d24_fields", 64'(|{id0, ra0, ca0, len0, wr0}), 64'h0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         tick();
         rst      = ($urandom_range(0, 99) == 0);
         a_valid  = ($urandom_range(0, 9) < 7);
         a_addr   = $urandom;
         a_id     = 4'($urandom);
         a_len    = 4'($urandom);
         a_wr     = 1'($urandom);
         for (int b = 0; b < 4; b++) bk_ready[b] = ($urandom_range(0, 9) < 4);
      end
      tick();
      rst = 1'b0;
      a_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
